// File: rtl/ysyx_25040101_mem_arbiter.sv
// Two-master (IFU/LSU) arbiter onto a single memory port. One transaction at a time,
// LSU preferred on contention with a starvation counter that eventually forces an IFU win.
module ysyx_25040101_mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [31:0] ifu_addr,
   output logic        ifu_resp_valid,
   input  logic        ifu_resp_ready,
   output logic [31:0] ifu_rdata,
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic [31:0] lsu_addr,
   input  logic        lsu_wen,
   input  logic [31:0] lsu_wdata,
   input  logic [3:0]  lsu_wmask,
   output logic        lsu_resp_valid,
   input  logic        lsu_resp_ready,
   output logic [31:0] lsu_rdata,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_resp_valid,
   output logic        mem_resp_ready,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  grant
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_IFU_REQ,
      S_IFU_RESP,
      S_LSU_REQ,
      S_LSU_RESP
   } state_t;

   state_t     r_state, w_next;
   logic [3:0] r_starve_cnt, w_starve_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_starve_cnt <= 4'd0;
      end else begin
         r_state      <= w_next;
         r_starve_cnt <= w_starve_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_starve_next = r_starve_cnt;
      case (r_state)
         S_IDLE: begin
            if (lsu_req_valid && ifu_req_valid) begin
               // Contested: LSU wins until it has won LIMIT times in a row.
               if (r_starve_cnt < LIMIT) begin
                  w_next = S_LSU_REQ;
                  if (r_starve_cnt != 4'hF) w_starve_next = r_starve_cnt + 4'd1;
               end else begin
                  w_next        = S_IFU_REQ;
                  w_starve_next = 4'd0;
               end
            end else if (lsu_req_valid) begin
               w_next = S_LSU_REQ;
            end else if (ifu_req_valid) begin
               w_next        = S_IFU_REQ;
               w_starve_next = 4'd0;
            end
         end
         S_IFU_REQ: begin
            if (ifu_req_valid && mem_req_ready) w_next = S_IFU_RESP;
            else if (!ifu_req_valid)            w_next = S_IDLE;
         end
         S_IFU_RESP: if (mem_resp_valid && ifu_resp_ready) w_next = S_IDLE;
         S_LSU_REQ: begin
            if (lsu_req_valid && mem_req_ready) w_next = S_LSU_RESP;
            else if (!lsu_req_valid)            w_next = S_IDLE;
         end
         S_LSU_RESP: if (mem_resp_valid && lsu_resp_ready) w_next = S_IDLE;
         default:    w_next = S_IDLE;
      endcase
   end

   // Outputs are pure steering from the owner; non-owner and idle paths are zero.
   always_comb begin
      grant          = 2'b00;
      mem_req_valid  = 1'b0;
      mem_addr       = 32'd0;
      mem_wen        = 1'b0;
      mem_wdata      = 32'd0;
      mem_wmask      = 4'd0;
      mem_resp_ready = 1'b0;
      ifu_req_ready  = 1'b0;
      ifu_resp_valid = 1'b0;
      ifu_rdata      = 32'd0;
      lsu_req_ready  = 1'b0;
      lsu_resp_valid = 1'b0;
      lsu_rdata      = 32'd0;
      case (r_state)
         S_IFU_REQ: begin
            grant         = 2'b01;
            mem_req_valid = ifu_req_valid;
            mem_addr      = ifu_addr;
            ifu_req_ready = mem_req_ready;
         end
         S_IFU_RESP: begin
            grant          = 2'b01;
            ifu_resp_valid = mem_resp_valid;
            ifu_rdata      = mem_rdata;
            mem_resp_ready = ifu_resp_ready;
         end
         S_LSU_REQ: begin
            grant         = 2'b10;
            mem_req_valid = lsu_req_valid;
            mem_addr      = lsu_addr;
            mem_wen       = lsu_wen;
            mem_wdata     = lsu_wdata;
            mem_wmask     = lsu_wmask;
            lsu_req_ready = mem_req_ready;
         end
         S_LSU_RESP: begin
            grant          = 2'b10;
            lsu_resp_valid = mem_resp_valid;
            lsu_rdata      = mem_rdata;
            mem_resp_ready = lsu_resp_ready;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ysyx_25040101_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: directed vector table, corner sequences,
// and random traffic against a transaction-level ownership model.
module tb_ysyx_25040101_mem_arbiter;

   localparam int LIM = 4;
   localparam logic [31:0] IA = 32'h8000_0000;
   localparam logic [31:0] LA = 32'h8000_1000;
   localparam logic [31:0] RD = 32'h0010_0073;

   logic        clk = 1'b0, rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;
   logic [1:0]  grant;

   ysyx_25040101_mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata),
      .grant(grant)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string nm, input logic [191:0] a, input logic [191:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", nm, a, e);
      end
   endtask

   // {grant, mem_req_valid, mem_wen, ifu_req_ready, lsu_req_ready, ifu_resp_valid, lsu_resp_valid, mem_resp_ready}
   function automatic logic [8:0] flags();
      return {grant, mem_req_valid, mem_wen, ifu_req_ready, lsu_req_ready,
              ifu_resp_valid, lsu_resp_valid, mem_resp_ready};
   endfunction

   typedef struct {
      logic        iv, lv, mrr, mrv, irr, lrr;
      logic [8:0]  flags;
      logic        ca;
      logic [31:0] addr;
      logic [63:0] rd;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mkv(logic iv, logic lv, logic mrr, logic mrv, logic irr, logic lrr,
                                logic [8:0] f, logic ca, logic [31:0] addr, logic [63:0] rd);
      vec_t v;
      v.iv = iv; v.lv = lv; v.mrr = mrr; v.mrv = mrv; v.irr = irr; v.lrr = lrr;
      v.flags = f; v.ca = ca; v.addr = addr; v.rd = rd;
      return v;
   endfunction

   task automatic clear_inputs();
      ifu_req_valid = 0; ifu_addr = IA; ifu_resp_ready = 0;
      lsu_req_valid = 0; lsu_addr = LA; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
      lsu_resp_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = RD;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      clear_inputs();
      repeat (2) @(negedge clk);
      rst = 0;
   endtask

   // Reference model: who owns the port, whether its request was accepted, LSU win streak.
   int   m_own = 0;
   bit   m_resp = 0;
   int   m_streak = 0;

   function automatic logic [191:0] model_out();
      logic [1:0] g = 0;
      logic mqv = 0, mw = 0, ir = 0, lr = 0, iv = 0, lv = 0, mrs = 0;
      logic [31:0] ad = 0, wd = 0, ird = 0, lrd = 0;
      logic [3:0] wm = 0;
      if (!rst && m_own != 0) begin
         g = 2'(m_own);
         if (!m_resp) begin
            mqv = (m_own == 1) ? ifu_req_valid : lsu_req_valid;
            ad  = (m_own == 1) ? ifu_addr : lsu_addr;
            if (m_own == 2) begin mw = lsu_wen; wd = lsu_wdata; wm = lsu_wmask; lr = mem_req_ready; end
            else ir = mem_req_ready;
         end else if (m_own == 1) begin
            iv = mem_resp_valid; ird = mem_rdata; mrs = ifu_resp_ready;
         end else begin
            lv = mem_resp_valid; lrd = mem_rdata; mrs = lsu_resp_ready;
         end
      end
      return 192'({g, mqv, mw, ir, lr, iv, lv, mrs, ad, wd, wm, ird, lrd});
   endfunction

   task automatic model_step();
      if (rst) begin
         m_own = 0; m_resp = 0; m_streak = 0;
      end else if (m_own == 0) begin
         m_resp = 0;
         if (lsu_req_valid && ifu_req_valid) begin
            if (m_streak < LIM) begin m_own = 2; if (m_streak < 15) m_streak++; end
            else begin m_own = 1; m_streak = 0; end
         end else if (lsu_req_valid) m_own = 2;
         else if (ifu_req_valid) begin m_own = 1; m_streak = 0; end
      end else if (!m_resp) begin
         logic v = (m_own == 1) ? ifu_req_valid : lsu_req_valid;
         if (v && mem_req_ready) m_resp = 1;
         else if (!v) m_own = 0;
      end else begin
         logic r = (m_own == 1) ? ifu_resp_ready : lsu_resp_ready;
         if (mem_resp_valid && r) begin m_own = 0; m_resp = 0; end
      end
   endtask

   initial begin
      logic [1:0] seq[$];
      logic [1:0] prev;
      logic [191:0] act;

      // Reset with every input active: outputs must stay quiet.
      rst = 1;
      clear_inputs();
      ifu_req_valid = 1; lsu_req_valid = 1; mem_req_ready = 1; mem_resp_valid = 1;
      repeat (2) @(negedge clk);
      #1;
      chk("reset flags", 192'(flags()), 192'(9'd0));
      chk("reset mem fields", 192'({mem_addr, mem_wdata, mem_wmask, mem_wen}), 192'(0));
      @(negedge clk);
      clear_inputs();
      rst = 0;

      vt.push_back(mkv(1,0,1,1,1,1, 9'b000000000, 1, 32'd0, 64'd0));
      vt.push_back(mkv(1,0,1,1,1,1, 9'b011010000, 1, IA,    64'd0));
      vt.push_back(mkv(1,0,1,1,1,1, 9'b010000101, 0, 32'd0, {RD, 32'd0}));
      vt.push_back(mkv(1,1,1,1,1,1, 9'b000000000, 1, 32'd0, 64'd0));
      vt.push_back(mkv(1,1,1,1,1,1, 9'b101101000, 1, LA,    64'd0));
      vt.push_back(mkv(1,0,1,1,1,1, 9'b100000011, 0, 32'd0, {32'd0, RD}));
      vt.push_back(mkv(1,0,1,1,1,1, 9'b000000000, 1, 32'd0, 64'd0));
      vt.push_back(mkv(1,0,1,1,1,1, 9'b011010000, 1, IA,    64'd0));
      vt.push_back(mkv(1,0,1,1,1,1, 9'b010000101, 0, 32'd0, {RD, 32'd0}));
      vt.push_back(mkv(1,1,0,0,1,1, 9'b000000000, 1, 32'd0, 64'd0));
      for (int i = 0; i < 5; i++)
         vt.push_back(mkv(1,1,0,0,1,1, 9'b101100000, 1, LA, 64'd0));
      vt.push_back(mkv(1,1,1,0,1,1, 9'b101101000, 1, LA,    64'd0));
      for (int i = 0; i < 3; i++)
         vt.push_back(mkv(1,0,0,1,1,0, 9'b100000010, 0, 32'd0, {32'd0, RD}));
      vt.push_back(mkv(1,0,0,1,1,1, 9'b100000011, 0, 32'd0, {32'd0, RD}));
      vt.push_back(mkv(0,0,0,0,0,0, 9'b000000000, 1, 32'd0, 64'd0));
      vt.push_back(mkv(0,0,0,0,0,0, 9'b000000000, 1, 32'd0, 64'd0));

      foreach (vt[i]) begin
         @(negedge clk);
         ifu_req_valid = vt[i].iv; lsu_req_valid = vt[i].lv; mem_req_ready = vt[i].mrr;
         mem_resp_valid = vt[i].mrv; ifu_resp_ready = vt[i].irr; lsu_resp_ready = vt[i].lrr;
         #1;
         chk($sformatf("vec %0d flags", i), 192'(flags()), 192'(vt[i].flags));
         chk($sformatf("vec %0d rdata", i), 192'({ifu_rdata, lsu_rdata}), 192'(vt[i].rd));
         if (vt[i].ca) chk($sformatf("vec %0d addr", i), 192'(mem_addr), 192'(vt[i].addr));
      end

      // Reset arriving mid-cycle while a response is being offered.
      @(negedge clk);
      ifu_req_valid = 1; mem_req_ready = 1; mem_resp_valid = 1; ifu_resp_ready = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("ifu_resp before reset", 192'(flags()), 192'(9'b010000100));
      #2 rst = 1;
      #1;
      chk("mid-cycle reset flags", 192'(flags()), 192'(9'd0));
      chk("mid-cycle reset data", 192'({mem_addr, ifu_rdata}), 192'(0));
      @(negedge clk);
      rst = 0; ifu_req_valid = 0;
      #1;
      chk("pending resp dropped", 192'(flags()), 192'(9'd0));

      // Starvation: both masters always requesting, memory always immediate.
      do_reset();
      ifu_req_valid = 1; lsu_req_valid = 1; mem_req_ready = 1; mem_resp_valid = 1;
      ifu_resp_ready = 1; lsu_resp_ready = 1;
      prev = 2'b00;
      for (int c = 0; c < 80 && seq.size() < 10; c++) begin
         @(negedge clk);
         #1;
         if (prev == 2'b00 && grant != 2'b00) seq.push_back(grant);
         prev = grant;
      end
      chk("starve grant count", 192'(seq.size()), 192'(10));
      foreach (seq[k]) chk($sformatf("starve grant %0d", k), 192'(seq[k]),
                           192'(((k % (LIM + 1)) == LIM) ? 2'b01 : 2'b10));

      // Random traffic against the ownership model.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         rst            = (c == 0) || ($urandom_range(0, 63) == 0);
         ifu_req_valid  = $urandom_range(0, 9) < 7;
         lsu_req_valid  = $urandom_range(0, 9) < 6;
         ifu_addr       = $urandom;
         lsu_addr       = $urandom;
         lsu_wen        = 1'($urandom_range(0, 1));
         lsu_wdata      = $urandom;
         lsu_wmask      = 4'($urandom_range(0, 15));
         mem_req_ready  = 1'($urandom_range(0, 1));
         mem_resp_valid = 1'($urandom_range(0, 1));
         mem_rdata      = $urandom;
         ifu_resp_ready = $urandom_range(0, 9) < 7;
         lsu_resp_ready = $urandom_range(0, 9) < 7;
         #1;
         act = 192'({grant, mem_req_valid, mem_wen, ifu_req_ready, lsu_req_ready, ifu_resp_valid,
                     lsu_resp_valid, mem_resp_ready, mem_addr, mem_wdata, mem_wmask, ifu_rdata, lsu_rdata});
         chk($sformatf("random cycle %0d", c), act, model_out());
         model_step();
      end
      @(negedge clk);
      rst = 0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
